mux4_arbiter: RTL and testbench

Round-robin arbiter and sequencer for a shared 4:1 mux, e.g. the register-file write-back path fed by four datapath sources.
- Accepts four request/last handshakes and grants exactly one requester at a time.
- Drives the mux select with a validity qualifier.
- Pre-empts a requester that holds the mux too long while others wait.
- All outputs are registered; the mux itself stays a separate combinational block.

---
 rtl/mux4_arbiter_pkg.sv | 20 ++
 rtl/mux4_arbiter_rr_pick4.sv | 26 ++
 rtl/mux4_arbiter.sv | 114 +++++++++++
 tb/tb_mux4_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_arbiter_pkg.sv
// Shared definitions for the 4-source round-robin mux arbiter: state encoding,
// requester count, select width and a one-hot helper.
package mux4_arbiter_pkg;

  localparam int NREQ  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_arbiter_rr_pick4.sv
// Combinational circular priority pick: first set request bit at or after start.
module rr_pick4
  import mux4_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] start,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = 0; i < NREQ; i++) begin
      cand = start + i[SEL_W-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 mux with hold-time pre-emption.
// Optional MUX4_ARB_STATS_EN adds saturating pre-emption and grant counters.
module mux4_arbiter
  import mux4_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  last,
  output logic [NREQ-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             sel_valid
`ifdef MUX4_ARB_STATS_EN
  ,
  output logic [15:0]      stat_preempt,
  output logic [15:0]      stat_grants
`endif
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  state_t           state;
  logic [SEL_W-1:0] rr_ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [NREQ-1:0]  others;
  logic [NREQ-1:0]  pick_req;
  logic [SEL_W-1:0] pick_start;
  logic [SEL_W-1:0] pick_idx;
  logic             pick_found;
  logic             req_g;
  logic             end_done;
  logic             end_abandon;
  logic             end_preempt;
  logic             end_any;

  // sel always encodes the current grant, so it doubles as the granted index.
  assign others      = req & ~onehot4(sel);
  assign req_g       = req[sel];
  assign end_done    = req_g & last[sel];
  assign end_abandon = ~req_g;
  assign end_preempt = req_g & ~last[sel] & (hold_cnt == HOLD_MAX) & (|others);
  assign end_any     = end_done | end_abandon | end_preempt;

  // The outgoing source is masked at handover; on abandon its req is already low.
  assign pick_req   = (state == ST_BUSY) ? others : req;
  assign pick_start = (state == ST_BUSY) ? sel + 1'b1 : rr_ptr;

  rr_pick4 u_pick (
    .req   (pick_req),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (pick_found) begin
        state     <= ST_BUSY;
        grant     <= onehot4(pick_idx);
        sel       <= pick_idx;
        sel_valid <= 1'b1;
        hold_cnt  <= HOLD_W'(1);
      end
    end else if (end_any) begin
      rr_ptr <= sel + 1'b1;
      if (pick_found) begin
        grant     <= onehot4(pick_idx);
        sel       <= pick_idx;
        sel_valid <= 1'b1;
        hold_cnt  <= HOLD_W'(1);
      end else begin
        state     <= ST_IDLE;
        grant     <= '0;
        sel       <= '0;
        sel_valid <= 1'b0;
        hold_cnt  <= '0;
      end
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

`ifdef MUX4_ARB_STATS_EN
  logic new_grant;
  logic preempt_evt;

  assign new_grant   = pick_found & ((state == ST_IDLE) | end_any);
  assign preempt_evt = (state == ST_BUSY) & end_preempt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_preempt <= '0;
      stat_grants  <= '0;
    end else begin
      if (preempt_evt && stat_preempt != 16'hFFFF)
        stat_preempt <= stat_preempt + 16'd1;
      if (new_grant && stat_grants != 16'hFFFF)
        stat_grants <= stat_grants + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux4_arbiter.sv
// Self-checking bench for mux4_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model (MUX4_ARB_STATS_EN aware).
module tb_mux4_arbiter;

  typedef struct {
    int cur;   // granted index, -1 when idle
    int held;  // consecutive granted cycles, unbounded
    int ptr;
    int pre;
    int grs;
  } model_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] last = '0;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       sel_valid;
`ifdef MUX4_ARB_STATS_EN
  logic [15:0] stat_preempt;
  logic [15:0] stat_grants;
`endif

  int  checks   = 0;
  int  failures = 0;
  bit  chk_en   = 1'b0;
  model_t m = '{-1, 0, 0, 0, 0};

  mux4_arbiter #(.MAX_HOLD(8), .HOLD_W(4)) dut (
    .clk       (clk),
    .reset     (rst),
    .req       (req),
    .last      (last),
    .grant     (grant),
    .sel       (sel),
    .sel_valid (sel_valid)
`ifdef MUX4_ARB_STATS_EN
    ,
    .stat_preempt (stat_preempt),
    .stat_grants  (stat_grants)
`endif
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic model_t next_model(input model_t s, input logic [3:0] r, input logic [3:0] l);
    model_t n = s;
    bit a, b, c;
    int w;
    if (s.cur < 0) begin
      w = pick(r, s.ptr);
      if (w >= 0) begin
        n.cur = w; n.held = 1;
        n.grs = (s.grs < 65535) ? s.grs + 1 : s.grs;
      end
    end else begin
      a = r[s.cur] && l[s.cur];
      b = !r[s.cur];
      c = (s.held >= 8) && ((r & ~(4'b1 << s.cur)) != 0);
      if (a || b || c) begin
        n.ptr = (s.cur + 1) % 4;
        if (c && !a && !b) n.pre = (s.pre < 65535) ? s.pre + 1 : s.pre;
        w = pick(r & ~(4'b1 << s.cur), n.ptr);
        if (w >= 0) begin
          n.cur = w; n.held = 1;
          n.grs = (s.grs < 65535) ? s.grs + 1 : s.grs;
        end else begin
          n.cur = -1; n.held = 0;
        end
      end else begin
        n.held = s.held + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= '{-1, 0, 0, 0, 0};
    else     m <= next_model(m, req, last);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_grant", 32'(grant), (m.cur < 0) ? 32'd0 : (32'd1 << m.cur));
      check("model_sel", 32'(sel), (m.cur < 0) ? 32'd0 : 32'(m.cur));
      check("model_sel_valid", 32'(sel_valid), (m.cur < 0) ? 32'd0 : 32'd1);
`ifdef MUX4_ARB_STATS_EN
      check("model_stat_preempt", 32'(stat_preempt), 32'(m.pre));
      check("model_stat_grants", 32'(stat_grants), 32'(m.grs));
`endif
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] l);
    @(negedge clk);
    req  = r;
    last = l;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    last = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_order [5];
    logic [3:0] r, flip, l;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_sel_valid", 32'(sel_valid), 32'd0);

    // Async reset mid-transfer.
    cyc(4'b0100, 4'b0000);
    check("t1_grant_before", 32'(grant), 32'h4);
    #2 rst = 1'b1; req = '0;
    #1;
    check("t1_async_grant", 32'(grant), 32'd0);
    check("t1_async_sel", 32'(sel), 32'd0);
    check("t1_async_valid", 32'(sel_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(4'b0100, 4'b0000);
    check("t1_regrant", 32'(grant), 32'h4);

    // Full round robin with back-to-back handover.
    do_reset();
    cyc(4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      check("t2_order", 32'(grant), 32'(exp_order[i]));
      if (i < 4) begin
        cyc(4'b1111, 4'b0000);
        check("t2_hold", 32'(grant), 32'(exp_order[i]));
        cyc(4'b1111, exp_order[i]);
      end
    end

    // Lone requester is never pre-empted.
    do_reset();
    cyc(4'b0001, 4'b0000);
    for (int i = 0; i < 20; i++) begin
      check("t3_lone", 32'(grant), 32'h1);
      cyc(4'b0001, 4'b0000);
    end

    // Pre-emption after exactly eight granted cycles.
    do_reset();
    cyc(4'b0011, 4'b0000);
    for (int i = 0; i < 7; i++) begin
      check("t4_held", 32'(grant), 32'h1);
      cyc(4'b0011, 4'b0000);
    end
    check("t4_held_last", 32'(grant), 32'h1);
    cyc(4'b0011, 4'b0000);
    check("t4_preempt", 32'(grant), 32'h2);
`ifdef MUX4_ARB_STATS_EN
    check("t4_stat_preempt", 32'(stat_preempt), 32'd1);
`endif

    // Abandon: req[2] drops, source 3 takes over.
    do_reset();
    cyc(4'b0100, 4'b0000);
    cyc(4'b1000, 4'b0000);
    check("t5_grant", 32'(grant), 32'h8);
    check("t5_sel", 32'(sel), 32'd3);

    // last coinciding with hold limit counts as completion.
    do_reset();
    cyc(4'b0010, 4'b0000);
    for (int i = 0; i < 7; i++) cyc(4'b1010, 4'b0000);
    check("t6_before", 32'(grant), 32'h2);
    cyc(4'b1010, 4'b0010);
    check("t6_grant", 32'(grant), 32'h8);
`ifdef MUX4_ARB_STATS_EN
    check("t6_stat_preempt", 32'(stat_preempt), 32'd0);
    check("t6_stat_grants", 32'(stat_grants), 32'd2);
`endif

    // Randomized traffic with sticky requests and occasional async resets.
    do_reset();
    r = '0;
    for (int n = 0; n < 3000; n++) begin
      flip = '0;
      l    = '0;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) flip[b] = 1'b1;
        if ($urandom_range(0, 5) == 0) l[b] = 1'b1;
      end
      r = r ^ flip;
      @(negedge clk);
      req  = r;
      last = l;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
